mb8_booth_enc: RTL

- Operand-side encoder that drives the radix-8 multiplier datapath (mb8_top / mb8_td).
- Holds a frozen (stationary) multiplicand `my` and precomputes `tmy = 3*my` once per load.
- Streams multiplier operands through a 2-stage valid/ready pipeline, emitting one-hot-per-group Booth select signals s/d/t/q plus negate n, alongside the frozen my/tmy.

---
 rtl/mb8_booth_enc.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mb8_booth_enc.sv
// Radix-8 Booth operand encoder: frozen multiplicand my with precomputed 3*my,
// and a 2-stage valid/ready pipeline that turns multiplier operands into per-group selects.
module mb8_booth_enc #(
    parameter int WIDTH     = 8,
    parameter int GROUP_CNT = (WIDTH >> 2) + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 w_load,
    input  logic [WIDTH-1:0]     w_data,
    output logic                 w_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GROUP_CNT-1:0] s,
    output logic [GROUP_CNT-1:0] d,
    output logic [GROUP_CNT-1:0] t,
    output logic [GROUP_CNT-1:0] q,
    output logic [GROUP_CNT-1:0] n,
    output logic [WIDTH-1:0]     my,
    output logic [WIDTH+1:0]     tmy
);

    localparam int XW = (3 * GROUP_CNT + 1 > WIDTH + 2) ? 3 * GROUP_CNT + 1 : WIDTH + 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        CALC  = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t             state;
    logic               a_valid;
    logic [WIDTH-1:0]   a_mx;
    logic               b_valid;
    logic               b_adv;
    logic               load;
    logic               accept;
    logic [XW-1:0]      xe;
    logic [3:0]         grp;
    logic [GROUP_CNT-1:0] enc_s, enc_d, enc_t, enc_q, enc_n;

    // A reload is only taken with both stages empty, so beats never mix multiplicands.
    assign w_ready   = (state != CALC) && !a_valid && !b_valid;
    assign load      = w_load && w_ready;
    assign b_adv     = !b_valid || out_ready;
    assign in_ready  = (state == HELD) && (!a_valid || b_adv) && !load;
    assign accept    = in_valid && in_ready;
    assign out_valid = b_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= EMPTY;
            my    <= '0;
            tmy   <= '0;
        end else begin
            case (state)
                EMPTY, HELD: begin
                    if (load) begin
                        state <= CALC;
                        my    <= w_data;
                    end
                end
                CALC: begin
                    state <= HELD;
                    tmy   <= {{2{my[WIDTH-1]}}, my} + {my[WIDTH-1], my, 1'b0};
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Overlapping 4-bit windows {x[3i+2], x[3i+1], x[3i], x[3i-1]}; 1111 decodes to zero.
    always_comb begin
        xe    = {{(XW - WIDTH - 1){a_mx[WIDTH-1]}}, a_mx, 1'b0};
        grp   = '0;
        enc_s = '0;
        enc_d = '0;
        enc_t = '0;
        enc_q = '0;
        enc_n = '0;
        for (int unsigned i = 0; i < GROUP_CNT; i++) begin
            grp = xe[3*i +: 4];
            case (grp)
                4'b0001, 4'b0010, 4'b1101, 4'b1110: enc_s[i] = 1'b1;
                4'b0011, 4'b0100, 4'b1011, 4'b1100: enc_d[i] = 1'b1;
                4'b0101, 4'b0110, 4'b1001, 4'b1010: enc_t[i] = 1'b1;
                4'b0111, 4'b1000:                   enc_q[i] = 1'b1;
                default: ;
            endcase
            enc_n[i] = grp[3] && (grp != 4'b1111);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_valid <= 1'b0;
            a_mx    <= '0;
            b_valid <= 1'b0;
            s       <= '0;
            d       <= '0;
            t       <= '0;
            q       <= '0;
            n       <= '0;
        end else begin
            if (accept) begin
                a_valid <= 1'b1;
                a_mx    <= mx;
            end else if (b_adv) begin
                a_valid <= 1'b0;
            end
            if (b_adv) begin
                b_valid <= a_valid;
                s       <= enc_s;
                d       <= enc_d;
                t       <= enc_t;
                q       <= enc_q;
                n       <= enc_n;
            end
        end
    end

endmodule
